// File: rtl/riscv_types_pkg.sv
// Shared types for the branch resolve unit: prediction FIFO entry, predictor
// update bundle and default sizing.
package riscv_types_pkg;

  localparam int ADDR_WIDTH        = 32;
  localparam int DEFAULT_BRU_DEPTH = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
    logic                  btb_hit;
  } bru_pred_entry_t;

  typedef struct packed {
    logic                  update;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  actual_taken;
    logic [ADDR_WIDTH-1:0] actual_target;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic [ADDR_WIDTH-1:0] jal_target;
  } bru_update_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order FIFO of prediction records. A flush consumes the head and
// discards every younger entry; any push in the flushing cycle is dropped.
module bru_pred_fifo
  import riscv_types_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BRU_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  bru_pred_entry_t entry_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            empty_o,
  output bru_pred_entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  bru_pred_entry_t  mem_q [DEPTH];
  logic             do_push, do_pop;

  assign ready_o = (count_q != CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && ready_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      wr_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; count_q guards every read, so stale data is never used.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches execute-side resolutions against buffered predictions, raising a
// redirect/flush on mispredict. Define BRANCH_RESOLVE_PERF_EN for perf counters.
module branch_resolve_unit
  import riscv_types_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_BRU_DEPTH,
  parameter int ADDR_W = ADDR_WIDTH  // must equal ADDR_WIDTH; entries are package structs
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pred_valid_i,
  output logic              pred_ready_o,
  input  logic [ADDR_W-1:0] pred_pc_i,
  input  logic              pred_taken_i,
  input  logic [ADDR_W-1:0] pred_target_i,
  input  logic              pred_btb_hit_i,
  input  logic              res_valid_i,
  input  logic              res_taken_i,
  input  logic [ADDR_W-1:0] res_target_i,
  input  logic              res_is_branch_i,
  input  logic              res_is_jal_i,
  input  logic              res_is_jalr_i,
  input  logic [ADDR_W-1:0] res_link_addr_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              update_o,
  output logic [ADDR_W-1:0] update_pc_o,
  output logic [ADDR_W-1:0] actual_target_o,
  output logic [ADDR_W-1:0] jal_target_o,
  output logic              actual_taken_o,
  output logic              is_branch_o,
  output logic              is_jal_o,
  output logic              is_jalr_o,
`ifdef BRANCH_RESOLVE_PERF_EN
  output logic [31:0]       perf_resolved_o,
  output logic [31:0]       perf_mispredict_o,
`endif
  output logic              empty_o,
  output logic              res_error_o
);

  bru_pred_entry_t push_entry, head;
  bru_update_t     upd_q;
  logic            fifo_empty, pop, eff_taken, mispredict;
  logic            redirect_q, res_error_q;
  logic [ADDR_W-1:0] redirect_pc_q;

  assign push_entry = '{pc: pred_pc_i, taken: pred_taken_i,
                        target: pred_target_i, btb_hit: pred_btb_hit_i};

  bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (pred_valid_i),
    .entry_i (push_entry),
    .pop_i   (res_valid_i),
    .flush_i (mispredict),
    .ready_o (pred_ready_o),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Jumps are unconditionally taken, whatever execute reports as direction.
  assign pop        = res_valid_i && !fifo_empty;
  assign eff_taken  = res_taken_i || res_is_jal_i || res_is_jalr_i;
  assign mispredict = pop && ((eff_taken != head.taken) ||
                              (eff_taken && (res_target_i != head.target)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      res_error_q   <= 1'b0;
    end else begin
      upd_q.update <= pop;
      redirect_q   <= mispredict;
      res_error_q  <= res_valid_i && fifo_empty;
      if (pop) begin
        upd_q.pc            <= head.pc;
        upd_q.actual_taken  <= eff_taken;
        upd_q.actual_target <= res_target_i;
        upd_q.is_branch     <= res_is_branch_i;
        upd_q.is_jal        <= res_is_jal_i;
        upd_q.is_jalr       <= res_is_jalr_i;
        upd_q.jal_target    <= res_link_addr_i;
        redirect_pc_q       <= eff_taken ? res_target_i : head.pc + ADDR_W'(4);
      end
    end
  end

  assign update_o        = upd_q.update;
  assign update_pc_o     = upd_q.pc;
  assign actual_taken_o  = upd_q.actual_taken;
  assign actual_target_o = upd_q.actual_target;
  assign is_branch_o     = upd_q.is_branch;
  assign is_jal_o        = upd_q.is_jal;
  assign is_jalr_o       = upd_q.is_jalr;
  assign jal_target_o    = upd_q.jal_target;
  assign redirect_o      = redirect_q;
  assign redirect_pc_o   = redirect_pc_q;
  assign res_error_o     = res_error_q;
  assign empty_o         = fifo_empty;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] perf_resolved_q, perf_mispredict_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_resolved_q   <= '0;
      perf_mispredict_q <= '0;
    end else begin
      if (pop && (perf_resolved_q != 32'hFFFF_FFFF))
        perf_resolved_q <= perf_resolved_q + 32'd1;
      if (mispredict && (perf_mispredict_q != 32'hFFFF_FFFF))
        perf_mispredict_q <= perf_mispredict_q + 32'd1;
    end
  end

  assign perf_resolved_o   = perf_resolved_q;
  assign perf_mispredict_o = perf_mispredict_q;
`endif

endmodule
